// File: rtl/dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// dispatch_sequencer
//   Control stage directly upstream of the activation/weight dispatcher.
//   The stage works through one tile at a time. For each tile it:
//     - pulls paired weight/activation words from the data buffer with a
//       valid/ready handshake;
//     - writes each pair into one of the dispatcher's two ping-pong slots;
//     - issues cfg_reuse read passes per word, with the latched broadcast modes;
//     - waits for the dispatcher's done pulse after every read.
//
// Optional feature macro: DISPATCH_TIMEOUT_EN
//   When defined, a WAIT-state counter aborts the tile if no done pulse
//   arrives within TO_CYC cycles. The abort sets the sticky err flag.
//   When undefined, WAIT waits forever and err stays 0.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   start                 one-cycle tile start (ignored while busy)
//   cfg_a_mode/cfg_w_mode broadcast modes, latched at start
//   cfg_num_words         word pairs in the tile, latched at start
//   cfg_reuse             read passes per word (0 behaves as 1), latched at start
//   src_valid/src_w/src_a source word pair; src_ready is combinational (LOAD only)
//   disp_wen, disp_*_write_address, disp_w_in, disp_a_in   dispatcher write side
//   disp_en, disp_*_read_address, disp_a_mode, disp_w_mode dispatcher read side
//   disp_done             dispatcher done pulse (2 cycles after disp_en)
//   busy                  high in every state except IDLE
//   finished              one-cycle pulse at tile end
//   err                   sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module dispatch_sequencer #(
   parameter int DATA_W = 1024,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 8,
   parameter int TO_CYC = 15
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [1:0]        cfg_a_mode,
   input  logic [1:0]        cfg_w_mode,
   input  logic [CNT_W-1:0]  cfg_num_words,
   input  logic [3:0]        cfg_reuse,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_w,
   input  logic [DATA_W-1:0] src_a,
   output logic              src_ready,
   output logic              disp_wen,
   output logic [ADDR_W-1:0] disp_w_write_address,
   output logic [ADDR_W-1:0] disp_a_write_address,
   output logic [DATA_W-1:0] disp_w_in,
   output logic [DATA_W-1:0] disp_a_in,
   output logic              disp_en,
   output logic [ADDR_W-1:0] disp_w_read_address,
   output logic [ADDR_W-1:0] disp_a_read_address,
   output logic [1:0]        disp_a_mode,
   output logic [1:0]        disp_w_mode,
   input  logic              disp_done,
   output logic              busy,
   output logic              finished,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_READ = 3'd2,
      ST_WAIT = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   state_t state_r, next_state_s;

   // Registered outputs and their next values
   logic              wen_r, wen_s;
   logic              en_r, en_s;
   logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
   logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
   logic [DATA_W-1:0] w_in_r, w_in_s;
   logic [DATA_W-1:0] a_in_r, a_in_s;
   logic [1:0]        a_mode_r, a_mode_s;
   logic [1:0]        w_mode_r, w_mode_s;
   logic              busy_r, busy_s;
   logic              finished_r, finished_s;
   logic              err_r, err_s;

   // Latched tile configuration and progress counters
   logic [CNT_W-1:0]  num_words_r, num_words_s;
   logic [3:0]        reuse_r, reuse_s;
   logic [1:0]        cfg_a_r, cfg_a_s;
   logic [1:0]        cfg_w_r, cfg_w_s;
   logic [CNT_W-1:0]  word_cnt_r, word_cnt_s;
   logic [3:0]        pass_cnt_r, pass_cnt_s;
   logic              slot_r, slot_s;

   // Decoded events
   logic              start_ok_s;
   logic              hs_s;
   logic              done_s;
   logic              last_pass_s;
   logic              last_word_s;
   logic              word_adv_s;
   logic              timeout_s;
   logic [ADDR_W-1:0] slot_addr_s;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC + 1);
   logic [TO_W-1:0] to_cnt_r, to_cnt_s;
   // The counter has seen TO_CYC WAIT cycles without a done pulse.
   assign timeout_s = (state_r == ST_WAIT) & ~disp_done & (to_cnt_r == TO_W'(TO_CYC - 1));
`else
   localparam int unused_to_cyc = TO_CYC;
   assign timeout_s = 1'b0;
`endif

   assign start_ok_s  = (state_r == ST_IDLE) & start;
   assign hs_s        = (state_r == ST_LOAD) & src_valid;
   assign done_s      = (state_r == ST_WAIT) & disp_done;
   // Compare one bit wider so that a full 2^CNT_W-1 tile cannot wrap.
   assign last_pass_s = ({1'b0, pass_cnt_r} + 5'd1) >= {1'b0, reuse_r};
   assign last_word_s = ({1'b0, word_cnt_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, num_words_r};
   assign word_adv_s  = done_s & last_pass_s;
   // Only bit 0 selects a ping-pong slot; the upper address bits stay 0.
   assign slot_addr_s = {{(ADDR_W-1){1'b0}}, slot_r};

   assign src_ready            = (state_r == ST_LOAD);
   assign disp_wen             = wen_r;
   assign disp_en              = en_r;
   assign disp_w_write_address = wr_addr_r;
   assign disp_a_write_address = wr_addr_r;
   assign disp_w_read_address  = rd_addr_r;
   assign disp_a_read_address  = rd_addr_r;
   assign disp_w_in            = w_in_r;
   assign disp_a_in            = a_in_r;
   assign disp_a_mode          = a_mode_r;
   assign disp_w_mode          = w_mode_r;
   assign busy                 = busy_r;
   assign finished             = finished_r;
   assign err                  = err_r;

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (cfg_num_words == {CNT_W{1'b0}}) begin
                  next_state_s = ST_FIN;
               end else begin
                  next_state_s = ST_LOAD;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (src_valid) begin
               next_state_s = ST_READ;
            end else begin
               next_state_s = ST_LOAD;
            end
         end
         ST_READ: begin
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (disp_done) begin
               if (!last_pass_s) begin
                  next_state_s = ST_READ;
               end else if (last_word_s) begin
                  next_state_s = ST_FIN;
               end else begin
                  next_state_s = ST_LOAD;
               end
            end else if (timeout_s) begin
               next_state_s = ST_FIN;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_FIN: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Output / datapath next-value logic (every output below is registered)
   always_comb begin
      // The write strobe fires only on a handshake and the read strobe only
      // from READ, so they can never coincide.
      wen_s       = hs_s;
      en_s        = (state_r == ST_READ);
      w_in_s      = hs_s ? src_w : w_in_r;
      a_in_s      = hs_s ? src_a : a_in_r;
      wr_addr_s   = hs_s ? slot_addr_s : wr_addr_r;
      rd_addr_s   = (state_r == ST_READ) ? slot_addr_s : rd_addr_r;
      a_mode_s    = (state_r == ST_READ) ? cfg_a_r : a_mode_r;
      w_mode_s    = (state_r == ST_READ) ? cfg_w_r : w_mode_r;
      finished_s  = (state_r == ST_FIN);
      busy_s      = (next_state_s != ST_IDLE);

      num_words_s = start_ok_s ? cfg_num_words : num_words_r;
      reuse_s     = start_ok_s ? ((cfg_reuse == 4'd0) ? 4'd1 : cfg_reuse) : reuse_r;
      cfg_a_s     = start_ok_s ? cfg_a_mode : cfg_a_r;
      cfg_w_s     = start_ok_s ? cfg_w_mode : cfg_w_r;

      word_cnt_s  = start_ok_s ? {CNT_W{1'b0}} :
                    (word_adv_s ? (word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) : word_cnt_r);
      pass_cnt_s  = start_ok_s ? 4'd0 :
                    (done_s ? (last_pass_s ? 4'd0 : (pass_cnt_r + 4'd1)) : pass_cnt_r);
      // The slot pointer persists across tiles; only reset returns it to 0.
      slot_s      = word_adv_s ? ~slot_r : slot_r;
      err_s       = start_ok_s ? 1'b0 : (timeout_s ? 1'b1 : err_r);
`ifdef DISPATCH_TIMEOUT_EN
      // WAIT is only ever entered from READ, so READ clears the counter.
      to_cnt_s    = (state_r == ST_READ) ? {TO_W{1'b0}} :
                    ((state_r == ST_WAIT) ? (to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1}) : to_cnt_r);
`endif
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wen_r       <= 1'b0;
         en_r        <= 1'b0;
         wr_addr_r   <= {ADDR_W{1'b0}};
         rd_addr_r   <= {ADDR_W{1'b0}};
         w_in_r      <= {DATA_W{1'b0}};
         a_in_r      <= {DATA_W{1'b0}};
         a_mode_r    <= 2'b00;
         w_mode_r    <= 2'b00;
         busy_r      <= 1'b0;
         finished_r  <= 1'b0;
         err_r       <= 1'b0;
         num_words_r <= {CNT_W{1'b0}};
         reuse_r     <= 4'd0;
         cfg_a_r     <= 2'b00;
         cfg_w_r     <= 2'b00;
         word_cnt_r  <= {CNT_W{1'b0}};
         pass_cnt_r  <= 4'd0;
         slot_r      <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
         to_cnt_r    <= {TO_W{1'b0}};
`endif
      end else begin
         wen_r       <= wen_s;
         en_r        <= en_s;
         wr_addr_r   <= wr_addr_s;
         rd_addr_r   <= rd_addr_s;
         w_in_r      <= w_in_s;
         a_in_r      <= a_in_s;
         a_mode_r    <= a_mode_s;
         w_mode_r    <= w_mode_s;
         busy_r      <= busy_s;
         finished_r  <= finished_s;
         err_r       <= err_s;
         num_words_r <= num_words_s;
         reuse_r     <= reuse_s;
         cfg_a_r     <= cfg_a_s;
         cfg_w_r     <= cfg_w_s;
         word_cnt_r  <= word_cnt_s;
         pass_cnt_r  <= pass_cnt_s;
         slot_r      <= slot_s;
`ifdef DISPATCH_TIMEOUT_EN
         to_cnt_r    <= to_cnt_s;
`endif
      end
   end

endmodule

// File: tb/tb_dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dispatch_sequencer
//   Randomised scoreboard bench for dispatch_sequencer. Stimulus tasks push
//   the expected write, read and finish events into queues. A negedge
//   monitor pops and compares them whenever the DUT raises disp_wen, disp_en
//   or finished.
//
//   Model used for the expectations:
//     - every word yields one write and max(reuse,1) reads to the current slot;
//     - the slot flips after each completed word;
//     - with no source stalls a tile finishes N*(4*R+1) cycles after the
//       first handshake, or 2 cycles after start for an empty tile.
//
//   A responder returns disp_done two cycles after every disp_en cycle.
// -----------------------------------------------------------------------------
module tb_dispatch_sequencer;

   localparam int DATA_W = 1024;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 8;
   localparam int TO_CYC = 15;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        cfg_a_mode = 2'b00;
   logic [1:0]        cfg_w_mode = 2'b00;
   logic [CNT_W-1:0]  cfg_num_words = '0;
   logic [3:0]        cfg_reuse = 4'd0;
   logic              src_valid = 1'b0;
   logic [DATA_W-1:0] src_w = '0;
   logic [DATA_W-1:0] src_a = '0;
   logic              src_ready;
   logic              disp_wen;
   logic [ADDR_W-1:0] disp_w_write_address;
   logic [ADDR_W-1:0] disp_a_write_address;
   logic [DATA_W-1:0] disp_w_in;
   logic [DATA_W-1:0] disp_a_in;
   logic              disp_en;
   logic [ADDR_W-1:0] disp_w_read_address;
   logic [ADDR_W-1:0] disp_a_read_address;
   logic [1:0]        disp_a_mode;
   logic [1:0]        disp_w_mode;
   logic              disp_done = 1'b0;
   logic              busy;
   logic              finished;
   logic              err;

   dispatch_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .cfg_a_mode(cfg_a_mode), .cfg_w_mode(cfg_w_mode),
      .cfg_num_words(cfg_num_words), .cfg_reuse(cfg_reuse),
      .src_valid(src_valid), .src_w(src_w), .src_a(src_a), .src_ready(src_ready),
      .disp_wen(disp_wen),
      .disp_w_write_address(disp_w_write_address), .disp_a_write_address(disp_a_write_address),
      .disp_w_in(disp_w_in), .disp_a_in(disp_a_in),
      .disp_en(disp_en),
      .disp_w_read_address(disp_w_read_address), .disp_a_read_address(disp_a_read_address),
      .disp_a_mode(disp_a_mode), .disp_w_mode(disp_w_mode),
      .disp_done(disp_done), .busy(busy), .finished(finished), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] w; logic [DATA_W-1:0] a; } wen_t;
   typedef struct { logic [ADDR_W-1:0] addr; logic [1:0] am; logic [1:0] wm; } en_t;
   typedef struct { logic err; int delta; } fin_t;

   wen_t wen_q[$];
   en_t  en_q[$];
   fin_t fin_q[$];

   int   checks = 0;
   int   errors = 0;
   int   ref_cyc = 0;
   bit   first_hs = 1'b0;
   int   m_reuse = 1;
   int   m_slot = 0;
   logic [1:0] m_am = 2'b00;
   logic [1:0] m_wm = 2'b00;
   bit   respond = 1'b1;
   bit   spur = 1'b0;
   bit   h0 = 1'b0;
   bit   h1 = 1'b0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_wide(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got low64 %h expected low64 %h (cycle %0d)", name, act[63:0], exp[63:0], cyc);
      end
   endtask

   function automatic logic [ADDR_W-1:0] slot_addr(int s);
      return ADDR_W'(s & 1);
   endfunction

   // Dispatcher model: done two cycles after each disp_en cycle, plus injected spurious pulses.
   initial begin
      forever begin
         @(negedge clk);
         disp_done = (h1 & respond) | spur;
         h1 = h0;
         h0 = disp_en;
      end
   end

   // Scoreboard monitor
   initial begin
      wen_t ew;
      en_t  ee;
      fin_t ef;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (disp_wen || disp_en)
               chk("wen_en_exclusive", 64'({disp_wen, disp_en} != 2'b11), 64'd1);
            if (disp_wen) begin
               if (wen_q.size() == 0) begin
                  chk("wen_unexpected", 64'd1, 64'd0);
               end else begin
                  ew = wen_q.pop_front();
                  chk("wen_w_addr", 64'(disp_w_write_address), 64'(ew.addr));
                  chk("wen_a_addr", 64'(disp_a_write_address), 64'(ew.addr));
                  chk_wide("wen_w_data", disp_w_in, ew.w);
                  chk_wide("wen_a_data", disp_a_in, ew.a);
               end
            end
            if (disp_en) begin
               if (en_q.size() == 0) begin
                  chk("en_unexpected", 64'd1, 64'd0);
               end else begin
                  ee = en_q.pop_front();
                  chk("en_w_addr", 64'(disp_w_read_address), 64'(ee.addr));
                  chk("en_a_addr", 64'(disp_a_read_address), 64'(ee.addr));
                  chk("en_a_mode", 64'(disp_a_mode), 64'(ee.am));
                  chk("en_w_mode", 64'(disp_w_mode), 64'(ee.wm));
               end
            end
            if (finished) begin
               if (fin_q.size() == 0) begin
                  chk("fin_unexpected", 64'd1, 64'd0);
               end else begin
                  ef = fin_q.pop_front();
                  chk("fin_err", 64'(err), 64'(ef.err));
                  chk("fin_busy_low", 64'(busy), 64'd0);
                  if (ef.delta >= 0) chk("fin_latency", 64'(cyc - ref_cyc), 64'(ef.delta));
                  chk("fin_wen_left", 64'(wen_q.size()), 64'd0);
                  chk("fin_en_left", 64'(en_q.size()), 64'd0);
               end
            end
         end
      end
   end

   // Start a tile; start is held a second cycle (ignored: busy or FIN) with scrambled config.
   task automatic start_tile(int num, int reuse, logic [1:0] am, logic [1:0] wm,
                             int delta, bit exp_err, bit push_fin);
      @(negedge clk);
      start = 1'b1;
      cfg_num_words = CNT_W'(num);
      cfg_reuse = 4'(reuse);
      cfg_a_mode = am;
      cfg_w_mode = wm;
      m_reuse = (reuse == 0) ? 1 : reuse;
      m_am = am;
      m_wm = wm;
      ref_cyc = cyc;
      first_hs = (num != 0);
      if (push_fin) fin_q.push_back('{exp_err, delta});
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("err_after_start", 64'(err), 64'd0);
      if (num == 0) chk("ready_empty_tile", 64'(src_ready), 64'd0);
      cfg_num_words = CNT_W'($urandom);
      cfg_reuse = 4'($urandom);
      cfg_a_mode = 2'($urandom);
      cfg_w_mode = 2'($urandom);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for LOAD, stall for gap cycles (optionally with a stray done), then hand over one pair.
   task automatic send_word(int gap, bit spurious);
      logic [DATA_W-1:0] w, a;
      int n;
      for (int i = 0; i < DATA_W / 32; i++) begin
         w[i*32 +: 32] = $urandom;
         a[i*32 +: 32] = $urandom;
      end
      src_valid = 1'b0;
      n = 0;
      while (!src_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("ready_wait_timeout", 64'd0, 64'd1);
      for (int g = 0; g < gap; g++) begin
         if (spurious && g == 1) spur = 1'b1;
         @(negedge clk);
         spur = 1'b0;
         chk("ready_during_stall", 64'(src_ready), 64'd1);
      end
      src_w = w;
      src_a = a;
      src_valid = 1'b1;
      wen_q.push_back('{slot_addr(m_slot), w, a});
      for (int p = 0; p < m_reuse; p++) en_q.push_back('{slot_addr(m_slot), m_am, m_wm});
      if (respond) m_slot ^= 1;
      @(negedge clk);
      if (first_hs) begin
         ref_cyc = cyc;
         first_hs = 1'b0;
      end
      src_valid = 1'b0;
   endtask

   task automatic wait_fin();
      int n;
      n = 0;
      while (fin_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         chk("fin_wait_timeout", 64'd0, 64'd1);
         fin_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_tile(int num, int reuse, logic [1:0] am, logic [1:0] wm,
                           int max_gap, bit spur_first);
      int r, delta, g;
      r = (reuse == 0) ? 1 : reuse;
      if (max_gap != 0) delta = -1;
      else if (num == 0) delta = 2;
      else delta = num * (4 * r + 1);
      start_tile(num, reuse, am, wm, delta, 1'b0, 1'b1);
      for (int i = 0; i < num; i++) begin
         g = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
         if (spur_first && i == 0) g = 4;
         send_word(g, spur_first && i == 0);
      end
      wait_fin();
   endtask

   task automatic do_reset();
      @(negedge clk);
      src_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      m_slot = 0;
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wen", 64'(disp_wen), 64'd0);
      chk("rst_en", 64'(disp_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_finished", 64'(finished), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_ready", 64'(src_ready), 64'd0);
      chk_wide("rst_w_in", disp_w_in, '0);
      chk("rst_wr_addr", 64'(disp_w_write_address), 64'd0);
      rstn = 1'b1;

      run_tile(3, 1, 2'b01, 2'b10, 0, 1'b0);       // basic 3-word tile, 15-cycle finish
      run_tile(1, 3, 2'b11, 2'b00, 0, 1'b0);       // reuse 3 on one slot
      run_tile(0, 2, 2'b01, 2'b01, 0, 1'b0);       // empty tile
      run_tile(2, 2, 2'b10, 2'b01, 4, 1'b1);       // stalls plus spurious done in LOAD
      run_tile(2, 0, 2'b00, 2'b11, 0, 1'b0);       // reuse 0 behaves as 1
      for (int t = 0; t < 8; t++)
         run_tile($urandom_range(1, 5), $urandom_range(0, 4), 2'($urandom), 2'($urandom),
                  (t % 2 == 0) ? 0 : 3, 1'b0);
      run_tile(255, 1, 2'b01, 2'b10, 0, 1'b0);     // full-width word count

      // Reset in the middle of LOAD with src_valid high
      start_tile(3, 1, 2'b10, 2'b10, -1, 1'b0, 1'b1);
      send_word(0, 1'b0);
      n = 0;
      while (!src_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_load_ready", 64'(src_ready), 64'd1);
      chk("mid_load_busy", 64'(busy), 64'd1);
      src_valid = 1'b1;
      rstn = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ready", 64'(src_ready), 64'd0);
      chk("abort_wen", 64'(disp_wen), 64'd0);
      chk("abort_en", 64'(disp_en), 64'd0);
      chk_wide("abort_w_in", disp_w_in, '0);
      chk_wide("abort_a_in", disp_a_in, '0);
      chk("abort_wr_addr", 64'(disp_w_write_address), 64'd0);
      chk("abort_rd_addr", 64'(disp_w_read_address), 64'd0);
      chk("abort_en_left", 64'(en_q.size()), 64'd0);
      fin_q.delete();
      m_slot = 0;
      @(negedge clk);
      src_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_abort_quiet", 64'({disp_wen, disp_en, busy}), 64'd0);
      end
      run_tile(3, 1, 2'b01, 2'b01, 0, 1'b0);       // slot pointer restarts at 0

      // Dispatcher never answers
      respond = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      start_tile(2, 1, 2'b01, 2'b10, TO_CYC + 2, 1'b1, 1'b1);
      send_word(0, 1'b0);
      wait_fin();
      chk("timeout_err_sticky", 64'(err), 64'd1);
      respond = 1'b1;
      run_tile(0, 1, 2'b00, 2'b00, 0, 1'b0);       // accepted start clears err
      chk("err_cleared", 64'(err), 64'd0);
`else
      start_tile(1, 1, 2'b01, 2'b10, -1, 1'b0, 1'b0);
      send_word(0, 1'b0);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy && !finished) n++;
      end
      chk("no_timeout_busy_cycles", 64'(n), 64'd60);
      chk("no_timeout_err", 64'(err), 64'd0);
      chk("no_timeout_en_left", 64'(en_q.size()), 64'd0);
      do_reset();
      respond = 1'b1;
      run_tile(2, 2, 2'b11, 2'b01, 0, 1'b0);
`endif

      repeat (4) @(negedge clk);
      chk("end_wen_q", 64'(wen_q.size()), 64'd0);
      chk("end_fin_q", 64'(fin_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
